// File: rtl/cam_buf_wr.sv
// Camera-side ping-pong frame buffer writer.
// Packs high-byte-first camera bytes into 16-bit pixels, writes them linearly
// into the selected buffer, and flags complete frames to the reader domain.
module cam_buf_wr #(
    parameter int H_ACTIVE  = 480,
    parameter int V_ACTIVE  = 272,
    parameter int ADDR_W    = 17,
    localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE
) (
    input  logic              iClk,
    input  logic              wRsn,
    input  logic              sw_i,
    input  logic              cam_vsync_i,
    input  logic              cam_hsync_i,
    input  logic [7:0]        cam_data_i,
    output logic              ram_wr_en_o,
    output logic [ADDR_W-1:0] ram_wr_addr_o,
    output logic [15:0]       ram_wr_data_o,
    output logic              buf_sel,
    output logic              buf0_full_wr,
    output logic              buf1_full_wr,
    output logic              fr_done
);

    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] L_FRAME = ADDR_W'(FRAME_PIX);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_vsync_d;
    logic              r_phase;
    logic [7:0]        r_hi;
    logic [ADDR_W-1:0] r_pix_cnt;

    logic w_fall;
    logic w_rise;
    logic w_start;
    logic w_end;
    logic w_lo;
    logic w_cnt_full;

    assign w_fall     = r_vsync_d & ~cam_vsync_i;
    assign w_rise     = ~r_vsync_d & cam_vsync_i;
    assign w_cnt_full = (r_pix_cnt == L_FRAME);

    // State register
    always_ff @(posedge iClk or negedge wRsn) begin
        if (!wRsn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and per-cycle control strobes; frame end beats a low byte
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_end       = 1'b0;
        w_lo        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall && !sw_i) begin
                    w_state_nxt = S_ACTIVE;
                    w_start     = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_rise) begin
                    w_state_nxt = S_IDLE;
                    w_end       = 1'b1;
                end else if (cam_hsync_i && r_phase) begin
                    w_lo = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Byte packing, pixel counter and vsync history
    always_ff @(posedge iClk or negedge wRsn) begin
        if (!wRsn) begin
            r_vsync_d <= 1'b0;
            r_phase   <= 1'b0;
            r_hi      <= 8'h00;
            r_pix_cnt <= '0;
        end else begin
            r_vsync_d <= cam_vsync_i;
            // Phase clears whenever hsync drops, dropping any odd trailing byte
            if (r_state == S_ACTIVE && !w_rise && cam_hsync_i) begin
                r_phase <= ~r_phase;
                if (!r_phase) r_hi <= cam_data_i;
            end else begin
                r_phase <= 1'b0;
            end
            if (w_start)                 r_pix_cnt <= '0;
            else if (w_lo && !w_cnt_full) r_pix_cnt <= r_pix_cnt + 1'b1;
        end
    end

    // Registered RAM write port; pixels past a full frame are discarded
    always_ff @(posedge iClk or negedge wRsn) begin
        if (!wRsn) begin
            ram_wr_en_o   <= 1'b0;
            ram_wr_addr_o <= '0;
            ram_wr_data_o <= 16'h0000;
        end else begin
            ram_wr_en_o <= 1'b0;
            if (w_lo && !w_cnt_full) begin
                ram_wr_en_o   <= 1'b1;
                ram_wr_addr_o <= r_pix_cnt;
                ram_wr_data_o <= {r_hi, cam_data_i};
            end
        end
    end

    // Buffer select, full flags and frame-done pulse
    always_ff @(posedge iClk or negedge wRsn) begin
        if (!wRsn) begin
            buf_sel      <= 1'b0;
            buf0_full_wr <= 1'b0;
            buf1_full_wr <= 1'b0;
            fr_done      <= 1'b0;
        end else begin
            fr_done <= 1'b0;
            // A buffer loses its full flag only when a new frame starts into it
            if (w_start) begin
                if (buf_sel) buf1_full_wr <= 1'b0;
                else         buf0_full_wr <= 1'b0;
            end
            // Short frames are dropped silently and the same buffer is reused
            if (w_end && w_cnt_full) begin
                if (buf_sel) buf1_full_wr <= 1'b1;
                else         buf0_full_wr <= 1'b1;
                buf_sel <= ~buf_sel;
                fr_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cam_buf_wr.sv
// Directed bench for cam_buf_wr using a reduced 16x8 frame.
module tb_cam_buf_wr;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int FP = H * V;   // 128 pixels per frame
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          wRsn = 1'b1;
    logic          sw_i = 1'b0;
    logic          cam_vsync_i = 1'b1;
    logic          cam_hsync_i = 1'b0;
    logic [7:0]    cam_data_i = 8'h00;
    logic          ram_wr_en_o;
    logic [AW-1:0] ram_wr_addr_o;
    logic [15:0]   ram_wr_data_o;
    logic          buf_sel;
    logic          buf0_full_wr;
    logic          buf1_full_wr;
    logic          fr_done;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state (written only by the monitor process)
    int          wr_tot = 0;
    int          wr_b1 = 0;
    int          fr_cnt = 0;
    int          bad_addr = 0;
    int          bad_data = 0;
    int          f_cnt = 0;
    logic        vs_q = 1'b1;
    logic [15:0] mem [FP];

    cam_buf_wr #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .iClk(clk), .wRsn(wRsn), .sw_i(sw_i),
        .cam_vsync_i(cam_vsync_i), .cam_hsync_i(cam_hsync_i), .cam_data_i(cam_data_i),
        .ram_wr_en_o(ram_wr_en_o), .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_data_o(ram_wr_data_o),
        .buf_sel(buf_sel), .buf0_full_wr(buf0_full_wr), .buf1_full_wr(buf1_full_wr),
        .fr_done(fr_done)
    );

    always #5 clk = ~clk;

    // Expected write address restarts at each vsync fall; pixel = {x, y}
    always @(negedge clk) begin
        if (vs_q && !cam_vsync_i) f_cnt = 0;
        vs_q = cam_vsync_i;
        if (!wRsn) f_cnt = 0;
        if (ram_wr_en_o) begin
            wr_tot++;
            if (buf_sel) wr_b1++;
            if (int'(ram_wr_addr_o) != f_cnt || int'(ram_wr_addr_o) >= FP) bad_addr++;
            if (ram_wr_data_o != {8'(f_cnt % H), 8'(f_cnt / H)}) bad_data++;
            if (int'(ram_wr_addr_o) < FP) mem[ram_wr_addr_o] = ram_wr_data_o;
            f_cnt++;
        end
        if (fr_done) fr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_fall();
        cam_vsync_i = 1'b0;
        repeat (3) tick();
    endtask

    task automatic vs_rise();
        cam_vsync_i = 1'b1;
        repeat (4) tick();
    endtask

    task automatic send_lines(input int n);
        for (int y = 0; y < n; y++) begin
            for (int x = 0; x < H; x++) begin
                cam_hsync_i = 1'b1;
                cam_data_i  = 8'(x);
                tick();
                cam_data_i  = 8'(y);
                tick();
            end
            cam_hsync_i = 1'b0;
            cam_data_i  = 8'($urandom);
            repeat (3) tick();
        end
    endtask

    task automatic full_frame(input int lines);
        vs_fall();
        send_lines(lines);
        vs_rise();
    endtask

    initial begin
        int w0, b0, f0;

        // T1: reset held with vsync high and random data
        #3 wRsn = 1'b0;
        repeat (5) begin
            cam_data_i = 8'($urandom);
            cam_hsync_i = 1'($urandom);
            tick();
        end
        cam_hsync_i = 1'b0;
        check("reset_ctl", {27'd0, ram_wr_en_o, buf_sel, buf0_full_wr, buf1_full_wr, fr_done}, 32'h0);
        check("reset_addr", 32'(ram_wr_addr_o), 32'h0);
        check("reset_data", 32'(ram_wr_data_o), 32'h0);
        check("reset_wr", wr_tot, 0);
        wRsn = 1'b1;
        repeat (3) tick();

        // T2: first full frame into Buf0
        w0 = wr_tot; f0 = fr_cnt;
        full_frame(V);
        check("f1_writes", wr_tot - w0, FP);
        check("f1_addr_seq", bad_addr, 0);
        check("f1_data", bad_data, 0);
        check("f1_mem_h1", 32'(mem[H+1]), 32'h0101);
        check("f1_mem_last", 32'(mem[FP-1]), 32'h0F07);
        check("f1_flags", {29'd0, buf_sel, buf0_full_wr, buf1_full_wr}, 32'b110);
        check("f1_frdone", fr_cnt - f0, 1);

        // T3: second frame goes to Buf1
        w0 = wr_tot; b0 = wr_b1; f0 = fr_cnt;
        full_frame(V);
        check("f2_writes_b1", wr_b1 - b0, FP);
        check("f2_writes", wr_tot - w0, FP);
        check("f2_flags", {29'd0, buf_sel, buf0_full_wr, buf1_full_wr}, 32'b011);
        check("f2_frdone", fr_cnt - f0, 1);

        // T3: third frame clears Buf0 flag at its start
        vs_fall();
        check("f3_start_flags", {29'd0, buf_sel, buf0_full_wr, buf1_full_wr}, 32'b001);
        send_lines(V);
        vs_rise();
        check("f3_end_flags", {29'd0, buf_sel, buf0_full_wr, buf1_full_wr}, 32'b111);

        // T4: short frame into Buf1, ending with hsync high on the vsync rise
        w0 = wr_tot; f0 = fr_cnt;
        vs_fall();
        send_lines(3);
        cam_hsync_i = 1'b1; cam_data_i = 8'hAA; tick();
        cam_vsync_i = 1'b1; cam_data_i = 8'h55; tick();
        cam_hsync_i = 1'b0;
        repeat (3) tick();
        check("short_writes", wr_tot - w0, 3 * H);
        check("short_frdone", fr_cnt - f0, 0);
        check("short_flags", {29'd0, buf_sel, buf0_full_wr, buf1_full_wr}, 32'b110);
        check("short_data", bad_data, 0);

        // T5: paused frame, then a normal frame into the same buffer
        w0 = wr_tot;
        sw_i = 1'b1;
        vs_fall();
        sw_i = 1'b0;
        send_lines(V);
        vs_rise();
        check("pause_writes", wr_tot - w0, 0);
        check("pause_flags", {29'd0, buf_sel, buf0_full_wr, buf1_full_wr}, 32'b110);
        w0 = wr_tot; b0 = wr_b1; f0 = fr_cnt;
        full_frame(V);
        check("resume_b1", wr_b1 - b0, FP);
        check("resume_flags", {29'd0, buf_sel, buf0_full_wr, buf1_full_wr}, 32'b011);
        check("resume_frdone", fr_cnt - f0, 1);

        // Overflow: one extra line is discarded, frame still completes
        w0 = wr_tot; f0 = fr_cnt;
        full_frame(V + 1);
        check("ovf_writes", wr_tot - w0, FP);
        check("ovf_addr", bad_addr, 0);
        check("ovf_flags", {29'd0, buf_sel, buf0_full_wr, buf1_full_wr}, 32'b111);
        check("ovf_frdone", fr_cnt - f0, 1);

        // T6: reset mid-frame while writing Buf1
        vs_fall();
        send_lines(3);
        cam_hsync_i = 1'b1; cam_data_i = 8'h12; tick();
        wRsn = 1'b0;
        #1;
        check("mid_rst_ctl", {27'd0, ram_wr_en_o, buf_sel, buf0_full_wr, buf1_full_wr, fr_done}, 32'h0);
        check("mid_rst_addr", 32'(ram_wr_addr_o), 32'h0);
        check("mid_rst_data", 32'(ram_wr_data_o), 32'h0);
        repeat (2) tick();
        cam_hsync_i = 1'b0;
        wRsn = 1'b1;
        w0 = wr_tot; f0 = fr_cnt;
        send_lines(4);
        vs_rise();
        check("post_rst_writes", wr_tot - w0, 0);
        check("post_rst_frdone", fr_cnt - f0, 0);
        w0 = wr_tot; b0 = wr_b1;
        full_frame(V);
        check("next_writes", wr_tot - w0, FP);
        check("next_b0", wr_b1 - b0, 0);
        check("next_addr", bad_addr, 0);
        check("next_flags", {29'd0, buf_sel, buf0_full_wr, buf1_full_wr}, 32'b110);
        check("all_data", bad_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
